tx_transmitter: RTL and testbench

Serial UART transmitter paired with `rx_receiver` on the same one-bit-per-clock serial channel. It accepts 16-bit data words over a valid/ready handshake and serialises them LSB-first as packets. Each packet is one start bit, then 1–8 words, each word being 1–16 data bits followed by an even-parity bit and stop time. The word geometry comes from `packet_struct`, using the same encoding as the receiver. Between words it honours the far end's `rx_ready` flow control, so consecutive words carry no start bit.

---
 rtl/tx_transmitter.sv | 142 ++++++++++++++
 tb/tb_tx_transmitter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_transmitter.sv
// Serial transmitter: packs 1-8 words of 1-16 data bits into a packet with one start bit.
// Each word is followed by even parity and stop time, and the far end's rx_ready gates the next word.
module tx_transmitter #(
    parameter int unsigned STOP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  packet_struct,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        rx_ready,
    output logic        serial_out,
    output logic        tx_busy,
    output logic        packet_done
);
    localparam int unsigned SW = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e        state_q, state_d;
    logic [15:0]   shift_q, shift_d;
    logic [3:0]    last_bit_q, last_bit_d;
    logic [2:0]    last_word_q, last_word_d;
    logic [2:0]    word_cnt_q, word_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          parity_q, parity_d;
    logic [SW-1:0] stop_cnt_q, stop_cnt_d;
    logic          serial_q, serial_d;
    logic          done_q, done_d;
    logic          stop_met, last_word;

    // Bit 4 of the geometry byte carries no meaning.
    logic unused_struct_bit;
    assign unused_struct_bit = packet_struct[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            last_bit_q  <= '0;
            last_word_q <= '0;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            parity_q    <= 1'b0;
            stop_cnt_q  <= '0;
            serial_q    <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            last_bit_q  <= last_bit_d;
            last_word_q <= last_word_d;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            parity_q    <= parity_d;
            stop_cnt_q  <= stop_cnt_d;
            serial_q    <= serial_d;
            done_q      <= done_d;
        end
    end

    // serial_d is the line value of the state being entered, so the flop shows it for the whole state.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        last_bit_d  = last_bit_q;
        last_word_d = last_word_q;
        word_cnt_d  = word_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        parity_d    = parity_q;
        stop_cnt_d  = stop_cnt_q;
        serial_d    = serial_q;
        done_d      = 1'b0;
        tx_ready    = 1'b0;
        stop_met    = (stop_cnt_q == STOP_LAST);
        last_word   = (word_cnt_q == last_word_q);

        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                serial_d = 1'b1;
                if (tx_valid) begin
                    shift_d     = tx_data;
                    last_bit_d  = packet_struct[3:0];
                    last_word_d = packet_struct[7:5];
                    word_cnt_d  = '0;
                    state_d     = START;
                    serial_d    = 1'b0;
                end
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
                parity_d  = 1'b0;
                serial_d  = shift_q[0];
            end
            DATA: begin
                parity_d  = parity_q ^ shift_q[bit_cnt_q];
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == last_bit_q) begin
                    state_d  = PARITY;
                    serial_d = parity_d;
                end else begin
                    serial_d = shift_q[bit_cnt_d];
                end
            end
            PARITY: begin
                state_d    = STOP;
                stop_cnt_d = '0;
                serial_d   = 1'b1;
            end
            STOP: begin
                serial_d = 1'b1;
                if (!stop_met) stop_cnt_d = stop_cnt_q + SW'(1);
                if (last_word) begin
                    if (stop_met) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tx_ready = rx_ready & stop_met;
                    if (tx_valid & tx_ready) begin
                        shift_d    = tx_data;
                        word_cnt_d = word_cnt_q + 3'd1;
                        bit_cnt_d  = '0;
                        parity_d   = 1'b0;
                        state_d    = DATA;
                        serial_d   = tx_data[0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign serial_out  = serial_q;
    assign tx_busy     = (state_q != IDLE);
    assign packet_done = done_q;

endmodule

// File: tb/tb_tx_transmitter.sv
// Directed bench for tx_transmitter: expected line bits are queued when a word is
// handed over and popped one per cycle as the line is sampled.
module tb_tx_transmitter;
    localparam int unsigned SC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  packet_struct = 8'h00;
    logic [15:0] tx_data = 16'h0000;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        rx_ready = 1'b1;
    logic        serial_out;
    logic        tx_busy;
    logic        packet_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];

    tx_transmitter #(.STOP_CYCLES(SC)) dut (
        .clk          (clk),
        .rst          (rst),
        .packet_struct(packet_struct),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_ready     (rx_ready),
        .serial_out   (serial_out),
        .tx_busy      (tx_busy),
        .packet_done  (packet_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit even_par(input logic [15:0] d, input int unsigned n);
        bit p = 1'b0;
        for (int unsigned i = 0; i < n; i++) p ^= d[i];
        return p;
    endfunction

    task automatic push_word(input logic [15:0] d, input int unsigned n, input bit with_start,
                             input int unsigned n_stop);
        if (with_start) exp_q.push_back(1'b0);
        for (int unsigned i = 0; i < n; i++) exp_q.push_back(d[i]);
        exp_q.push_back(even_par(d, n));
        for (int unsigned i = 0; i < n_stop; i++) exp_q.push_back(1'b1);
    endtask

    // Handshake: holds tx_valid until accepted, bounded.
    task automatic send(input string tag, input logic [15:0] d, input logic [7:0] ps);
        int unsigned w = 0;
        tx_data       = d;
        packet_struct = ps;
        tx_valid      = 1'b1;
        while (tx_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk({tag, "_hs_wait"}, 32'(w < 50), 32'd1);
        tick();
        tx_valid = 1'b0;
        tx_data  = 16'($urandom);
    endtask

    task automatic drain(input string tag, output int busy_n);
        bit e;
        int k = 0;
        busy_n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_line%0d", tag, k), serial_out, e);
            chk($sformatf("%s_ready%0d", tag, k), tx_ready, 1'b0);
            chk($sformatf("%s_done%0d", tag, k), packet_done, 1'b0);
            if (tx_busy === 1'b1) busy_n++;
            k++;
            tick();
        end
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_pdone"}, packet_done, 1'b1);
        chk({tag, "_idle_ready"}, tx_ready, 1'b1);
        chk({tag, "_idle_busy"}, tx_busy, 1'b0);
        chk({tag, "_idle_line"}, serial_out, 1'b1);
    endtask

    initial begin
        int bn;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_line", serial_out, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_pdone", packet_done, 1'b0);
        tick();

        // Basic 8-bit word
        send("basic", 16'h00A5, 8'h07);
        push_word(16'h00A5, 8, 1'b1, SC);
        drain("basic", bn);
        chk_done("basic");
        tick();
        chk("basic_pulse_one", packet_done, 1'b0);

        // Full 16-bit word
        send("full", 16'h8001, 8'h0F);
        push_word(16'h8001, 16, 1'b1, SC);
        drain("full", bn);
        chk("full_busy_len", bn, 19);
        chk_done("full");
        tick();

        // Flow control: two 4-bit words, far end stalls after the first
        rx_ready = 1'b0;
        send("flow_w1", 16'h0003, 8'h23);
        push_word(16'h0003, 4, 1'b1, 0);
        drain("flow_w1", bn);
        tx_valid = 1'b1;
        tx_data  = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("flow_hold_line%0d", i), serial_out, 1'b1);
            chk($sformatf("flow_hold_ready%0d", i), tx_ready, 1'b0);
            tick();
        end
        rx_ready = 1'b1;
        #1;
        chk("flow_ready_release", tx_ready, 1'b1);
        send("flow_w2", 16'h0001, 8'hFF);
        push_word(16'h0001, 4, 1'b0, SC);
        drain("flow_w2", bn);
        chk_done("flow");
        tick();

        // Three 3-bit words, no stall: next word immediately after one stop cycle
        send("multi_w1", 16'h0005, 8'h42);
        push_word(16'h0005, 3, 1'b1, 0);
        drain("multi_w1", bn);
        chk("multi_stop1", serial_out, 1'b1);
        send("multi_w2", 16'h0006, 8'h00);
        push_word(16'h0006, 3, 1'b0, 0);
        drain("multi_w2", bn);
        chk("multi_stop2", serial_out, 1'b1);
        send("multi_w3", 16'h0007, 8'h0F);
        push_word(16'h0007, 3, 1'b0, SC);
        drain("multi_w3", bn);
        chk_done("multi");
        tick();

        // Reset in the middle of a data word
        send("rmid", 16'h00A5, 8'h07);
        push_word(16'h00A5, 8, 1'b1, SC);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rmid_pre%0d", i), serial_out, exp_q.pop_front());
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("rmid_line", serial_out, 1'b1);
        chk("rmid_busy", tx_busy, 1'b0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("rmid_nodone%0d", i), packet_done, 1'b0);
            tick();
        end
        send("rmid_after", 16'h005A, 8'h07);
        push_word(16'h005A, 8, 1'b1, SC);
        drain("rmid_after", bn);
        chk_done("rmid_after");
        tick();

        // 1-bit word, geometry changed mid-frame, then back-to-back 16-bit packet
        send("snap1", 16'hFFFF, 8'h00);
        packet_struct = 8'h0F;
        push_word(16'hFFFF, 1, 1'b1, SC);
        drain("snap1", bn);
        chk_done("snap1");
        send("snap2", 16'hC3A5, 8'h0F);
        push_word(16'hC3A5, 16, 1'b1, SC);
        drain("snap2", bn);
        chk_done("snap2");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
